// File: rtl/shift_issue_stage_if.sv
// ---------------------------------------------------------------------------
// shift_issue_stage_if
// Bus bundle between register-file read (ID) and the shift/lui issue stage.
//   Upstream side   : flush, in_valid, in_ready, instr, rs_val, rt_val
//   Downstream side : out_valid, out_ready, A, B, Shamt, sel, rd, wr_en, out_hit
// Modports:
//   slave  - the issue stage (consumes instr/operands, produces operands)
//   master - the surrounding pipeline (drives instr/operands, consumes result)
// ---------------------------------------------------------------------------
interface shift_issue_stage_if #(
    parameter int N     = 32,
    parameter int REG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [N-1:0]     rs_val;
    logic [N-1:0]     rt_val;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [4:0]       Shamt;
    logic [1:0]       sel;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             out_hit;

    modport slave (
        input  flush, in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, A, B, Shamt, sel, rd, wr_en, out_hit
    );

    modport master (
        output flush, in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, A, B, Shamt, sel, rd, wr_en, out_hit
    );
endinterface

// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage
// Decode/issue register in front of the shift/lui unit in the EX path.
// Decodes sll/srl/sra, sllv/srlv/srav and lui, picks the shift amount
// (instruction field or rs_val[4:0]) and registers A, B, Shamt, sel, rd,
// wr_en and out_hit behind a single-entry valid/ready pipeline register.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every output register
//   bus    - shift_issue_stage_if.slave (handshake, instruction, operands,
//            registered decode results; see the interface header)
// ---------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int N     = 32,
    parameter int REG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_issue_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        SEL_SLL = 2'b00,
        SEL_SRL = 2'b01,
        SEL_SRA = 2'b10,
        SEL_LUI = 2'b11
    } sel_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // ---------------- combinational decode ----------------
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [N-1:0]     b_d;
    logic [4:0]       shamt_d;
    sel_e             sel_d;
    logic [REG_W-1:0] rd_d;
    logic             hit_d;
    logic             wr_en_d;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        b_d     = bus.rt_val;
        shamt_d = 5'd0;
        sel_d   = SEL_SLL;
        rd_d    = '0;
        hit_d   = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                6'h00, 6'h02, 6'h03: begin
                    hit_d   = 1'b1;
                    shamt_d = bus.instr[10:6];
                    rd_d    = REG_W'(bus.instr[15:11]);
                end
                6'h04, 6'h06, 6'h07: begin
                    hit_d   = 1'b1;
                    // Only the low five bits of rs form the amount; A still
                    // carries the full rs value.
                    shamt_d = bus.rs_val[4:0];
                    rd_d    = REG_W'(bus.instr[15:11]);
                end
                default: ;
            endcase
            // funct[1:0] encodes the direction for both fixed and variable forms.
            if (hit_d) begin
                case (funct[1:0])
                    2'b10:   sel_d = SEL_SRL;
                    2'b11:   sel_d = SEL_SRA;
                    default: sel_d = SEL_SLL;
                endcase
            end
        end else if (opcode == OP_LUI) begin
            hit_d = 1'b1;
            sel_d = SEL_LUI;
            b_d   = {{(N-16){1'b0}}, bus.instr[15:0]};
            rd_d  = REG_W'(bus.instr[20:16]);
        end
        // Writes to $0 are suppressed, so a nop decodes as hit without write.
        wr_en_d = hit_d && (rd_d != '0);
    end

    // ---------------- handshake ----------------
    logic out_valid_q;
    logic load;

    // Flush deliberately does not gate in_ready; it only blocks the load.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // ---------------- pipeline register ----------------
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [4:0]       shamt_q;
    logic [1:0]       sel_q;
    logic [REG_W-1:0] rd_q;
    logic             wr_en_q;
    logic             hit_q;

    // NOTE: the data registers are reset along with out_valid because the
    // outputs must read all-zero during reset, not just be marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else if (bus.flush) begin
            // Squash wins over both load and consume; data simply holds.
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            a_q         <= bus.rs_val;
            b_q         <= b_d;
            shamt_q     <= shamt_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            wr_en_q     <= wr_en_d;
            hit_q       <= hit_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Shamt     = shamt_q;
    assign bus.sel       = sel_q;
    assign bus.rd        = rd_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.out_hit   = hit_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_issue_stage
// Directed bench for shift_issue_stage: decode of each instruction class,
// back-pressure, flush and asynchronous reset, with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_shift_issue_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_issue_stage_if #(.N(32), .REG_W(5)) bus ();

    shift_issue_stage #(.N(32), .REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against an expected set.
    task automatic check_out(input string tag,
                             input logic        e_valid,
                             input logic [31:0] e_a,
                             input logic [31:0] e_b,
                             input logic [4:0]  e_shamt,
                             input logic [1:0]  e_sel,
                             input logic [4:0]  e_rd,
                             input logic        e_wr,
                             input logic        e_hit);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e_valid));
        check({tag, ".A"},         bus.A,              e_a);
        check({tag, ".B"},         bus.B,              e_b);
        check({tag, ".Shamt"},     32'(bus.Shamt),     32'(e_shamt));
        check({tag, ".sel"},       32'(bus.sel),       32'(e_sel));
        check({tag, ".rd"},        32'(bus.rd),        32'(e_rd));
        check({tag, ".wr_en"},     32'(bus.wr_en),     32'(e_wr));
        check({tag, ".out_hit"},   32'(bus.out_hit),   32'(e_hit));
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset state
        step();
        step();
        check_out("reset", 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // T1: sll $3,$2,6
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h00021980, 32'h11, 32'hABC);
        step();
        check_out("t1_sll", 1'b1, 32'h11, 32'hABC, 5'd6, 2'b00, 5'd3, 1'b1, 1'b1);

        // T2: srav $4,$5,$6 back-to-back
        drive(1'b1, 32'h00C52007, 32'h26, 32'hFFFFBBCC);
        step();
        check_out("t2_srav", 1'b1, 32'h26, 32'hFFFFBBCC, 5'd6, 2'b10, 5'd4, 1'b1, 1'b1);

        // sllv $9,$8,$1: only rs_val[4:0] forms Shamt, A keeps full rs
        drive(1'b1, 32'h00284804, 32'h12345ABC, 32'h0F0F0F0F);
        step();
        check_out("sllv_wide_rs", 1'b1, 32'h12345ABC, 32'h0F0F0F0F, 5'd28, 2'b00, 5'd9, 1'b1, 1'b1);

        // srl $0,$2,31: hit but no writeback
        drive(1'b1, 32'h000207C2, 32'h1, 32'h80000000);
        step();
        check_out("srl_rd0", 1'b1, 32'h1, 32'h80000000, 5'd31, 2'b01, 5'd0, 1'b0, 1'b1);

        // nop (sll $0,$0,0)
        drive(1'b1, 32'h00000000, 32'h0, 32'h0);
        step();
        check_out("nop", 1'b1, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1);

        // T3: lui $7,0xBBCC
        drive(1'b1, 32'h3C07BBCC, 32'h3, 32'h55555555);
        step();
        check_out("t3_lui", 1'b1, 32'h3, 32'h0000BBCC, 5'd0, 2'b11, 5'd7, 1'b1, 1'b1);

        // addu: passthrough, A/B still loaded
        drive(1'b1, 32'h00431021, 32'hAAAA0001, 32'hBBBB0002);
        step();
        check_out("t3_addu", 1'b1, 32'hAAAA0001, 32'hBBBB0002, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

        // T4: sra $10,$11,5 then stall three cycles
        drive(1'b1, 32'h000B5143, 32'h44, 32'hF0000000);
        step();
        check_out("t4_load", 1'b1, 32'h44, 32'hF0000000, 5'd5, 2'b10, 5'd10, 1'b1, 1'b1);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h3C081234, 32'h99, 32'h77);
        #1;
        check("t4_stall.in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall.in_ready", 32'(bus.in_ready), 32'd0);
            check_out("t4_stall", 1'b1, 32'h44, 32'hF0000000, 5'd5, 2'b10, 5'd10, 1'b1, 1'b1);
        end
        // Release: consume and load on the same edge, no bubble
        bus.out_ready = 1'b1;
        #1;
        check("t4_release.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_out("t4_nobubble", 1'b1, 32'h99, 32'h00001234, 5'd0, 2'b11, 5'd8, 1'b1, 1'b1);

        // Drain: valid drops, data holds
        drive(1'b0, 32'h00021980, 32'h5, 32'h6);
        step();
        check_out("drain", 1'b0, 32'h99, 32'h00001234, 5'd0, 2'b11, 5'd8, 1'b1, 1'b1);

        // T5: load sll $3,$2,6, then flush with a lui incoming
        drive(1'b1, 32'h00021980, 32'h10, 32'h77);
        step();
        check_out("t5_load", 1'b1, 32'h10, 32'h77, 5'd6, 2'b00, 5'd3, 1'b1, 1'b1);
        bus.flush = 1'b1;
        drive(1'b1, 32'h3C09DEAD, 32'h20, 32'h30);
        #1;
        check("t5_flush.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_out("t5_flush", 1'b0, 32'h10, 32'h77, 5'd6, 2'b00, 5'd3, 1'b1, 1'b1);
        bus.flush = 1'b0;
        drive(1'b0, 32'h3C09DEAD, 32'h20, 32'h30);
        step();
        check_out("t5_after", 1'b0, 32'h10, 32'h77, 5'd6, 2'b00, 5'd3, 1'b1, 1'b1);

        // Flush while stalled also drops valid
        drive(1'b1, 32'h000207C2, 32'h8, 32'h9);
        step();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        check("flush_stalled.out_valid", 32'(bus.out_valid), 32'd0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // T6: asynchronous reset mid-cycle with valid data held
        drive(1'b1, 32'h000B5143, 32'hCAFE, 32'hBEEF);
        step();
        check_out("t6_pre", 1'b1, 32'hCAFE, 32'hBEEF, 5'd5, 2'b10, 5'd10, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t6_async", 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        check("t6_async.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_out("t6_held", 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 32'h3C07BBCC, 32'h1, 32'h2);
        step();
        check_out("t6_resume", 1'b1, 32'h1, 32'h0000BBCC, 5'd0, 2'b11, 5'd7, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
